can_rx_sequencer: RTL and testbench
===================================

// Module: can_rx_sequencer
// PURPOSE
//  Front-end sequencer between the bit sampler and candecoder. Detects bus idle and SOF,
//  removes stuff bits and checks the stuff rule. Computes CAN CRC-15 over destuffed
//  SOF..data bits and forwards only destuffed bits as a one-cycle strobe.
//  Decoder handshakes (crc_stop, stuff_stop, frame_done) mark field boundaries.
// PARAMETERS
//  IDLE_BITS  11        consecutive recessive bits required before SOF is accepted
//  STUFF_LEN  5         equal bits after which a complementary stuff bit follows
//  CRC_POLY   15'h4599  CAN CRC-15 generator polynomial (x^15 term implicit)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   synchronous active-low reset
//  sample_en   in   1   one-cycle strobe at the bit sample point
//  rx_bit      in   1   sampled bus level (1 = recessive), valid when sample_en=1
//  crc_stop    in   1   pulse from decoder: last data bit consumed; freeze CRC
//  stuff_stop  in   1   pulse from decoder: CRC sequence consumed; stop destuffing
//  frame_done  in   1   pulse from decoder: EOF/error delimiter done; re-arm
//  bit_out     out  1   destuffed bit to decoder
//  bit_valid   out  1   one-cycle strobe, bit_out valid
//  sof         out  1   one-cycle strobe coincident with bit_valid of the SOF bit
//  crc_out     out  15  computed CRC-15, stable while crc_valid=1
//  crc_valid   out  1   level: CRC frozen, held until next SOF
//  stuff_err   out  1   one-cycle pulse on stuff-rule violation
//  busy        out  1   high from SOF until re-armed (frame_done or error recovery)
//  seq_state   out  3   current FSM state (debug)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): state=WAIT_IDLE (0); idle_cnt=0; stuff_cnt=0;
//   crc=0; all outputs 0. Reset takes effect mid-frame with no flush.
//  Latency: bit_valid/bit_out/sof registered one clk after the sample_en cycle.
//   Stuff bits produce no bit_valid.
//  States (seq_state encoding):
//   WAIT_IDLE(0): on sample_en, rx_bit=1 -> idle_cnt++ (saturates at IDLE_BITS);
//    rx_bit=0 -> idle_cnt=0. When idle_cnt reaches IDLE_BITS -> IDLE.
//   IDLE(1): on sample_en, rx_bit=0 is SOF: emit bit, sof=1, busy=1, crc=0,
//    crc_valid=0, prev=0, stuff_cnt=1, CRC updated with 0 -> STUFF.
//   STUFF(2): on sample_en:
//    if stuff_cnt==STUFF_LEN: rx_bit!=prev -> drop bit, prev=rx_bit, stuff_cnt=1;
//     rx_bit==prev -> stuff_err=1 -> ERROR.
//    else: emit bit; stuff_cnt = (rx_bit==prev) ? stuff_cnt+1 : 1; prev=rx_bit;
//     if crc_valid=0, update CRC.
//    stuff_stop -> NOSTUFF.
//   NOSTUFF(3): every sample_en emits rx_bit, no stuff checking. frame_done -> WAIT_IDLE.
//   ERROR(4): busy stays 1; idle_cnt=0; frame_done or IDLE_BITS recessive bits
//    -> WAIT_IDLE.
//  CRC update per emitted bit b: n = b ^ crc[14]; crc = {crc[13:0],1'b0} ^ (n ? CRC_POLY : 0).
//  crc_stop (STUFF only): next clk crc_valid=1 and crc_out=crc; no further updates.
//   Ignored in any other state.
//  Simultaneous events:
//   crc_stop and stuff_stop in the same clk: both take effect.
//   A strobe coinciding with sample_en takes effect before that bit is processed
//    (a frozen CRC excludes that bit; stuff_stop suppresses the stuff check on it).
//   frame_done in STUFF: abort to WAIT_IDLE, busy=0, no error.
//  busy clears on the clk the FSM enters WAIT_IDLE.
//  crc_out/crc_valid hold through WAIT_IDLE/IDLE until the next SOF.
//  sample_en=0: state, counters and CRC are frozen; bit_valid=0.
// TESTING
//  1 Reset then 10 recessive bits, then 0 -> no sof; after the 11th recessive bit,
//    a 0 -> sof=1 and bit_valid=1 exactly 1 clk after sample_en.
//  2 After SOF, raw 0,0,0,0,1(stuff),0 -> bit_valid only for the 0s; stuff bit
//    dropped; stuff_err=0; bit_out sequence 0,0,0,0,0.
//  3 After SOF 0,0,0,0, a raw 0 -> stuff_err pulse 1 clk, seq_state=4; after 11
//    recessive bits -> seq_state=0 then 1; busy=0.
//  4 Std data frame ID=0x123, DLC=1, data 0xA5 (stuffed), crc_stop after the last
//    data bit -> crc_valid=1 and crc_out equals the golden-model CRC-15.
//  5 stuff_stop then 6 raw 1s -> 6 bit_valid, no stuff_err; frame_done -> WAIT_IDLE.
//  6 rst_n=0 for 1 clk mid-data -> all outputs 0, seq_state=0; a dominant bit
//    before 11 recessive bits -> no sof.

Source files
------------

// File: rtl/can_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : can_rx_sequencer
// Purpose  : CAN receive front end. Detects bus idle and SOF, removes stuff
//            bits and checks the stuff rule, accumulates CRC-15 over destuffed
//            SOF..data bits and forwards destuffed bits as one-cycle strobes.
// Revision : 1.0  initial release
// ============================================================================
module can_rx_sequencer #(
  parameter int          IDLE_BITS = 11,
  parameter int          STUFF_LEN = 5,
  parameter logic [14:0] CRC_POLY  = 15'h4599
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sample_en,
  input  logic        i_rx_bit,
  input  logic        i_crc_stop,
  input  logic        i_stuff_stop,
  input  logic        i_frame_done,
  output logic        o_bit_out,
  output logic        o_bit_valid,
  output logic        o_sof,
  output logic [14:0] o_crc_out,
  output logic        o_crc_valid,
  output logic        o_stuff_err,
  output logic        o_busy,
  output logic [2:0]  o_seq_state
);

  localparam int c_IDLE_W  = $clog2(IDLE_BITS + 1);
  localparam int c_STUFF_W = $clog2(STUFF_LEN + 1);
  localparam logic [c_IDLE_W-1:0]  c_IDLE_MAX  = c_IDLE_W'(IDLE_BITS);
  localparam logic [c_STUFF_W-1:0] c_STUFF_MAX = c_STUFF_W'(STUFF_LEN);
  localparam logic [c_STUFF_W-1:0] c_STUFF_ONE = c_STUFF_W'(1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_STUFF     = 3'd2,
    S_NOSTUFF   = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_IDLE_W-1:0]   r_idle_cnt, w_idle_nxt, w_idle_inc;
  logic [c_STUFF_W-1:0]  r_stuff_cnt, w_stuff_nxt;
  logic                  r_prev, w_prev_nxt;
  logic [14:0]           r_crc, w_crc_nxt;
  logic                  r_crc_valid, w_crc_valid_nxt;
  logic                  r_bit_out, w_bit_out_nxt;
  logic                  r_bit_valid, w_bit_valid_nxt;
  logic                  r_sof, w_sof_nxt;
  logic                  r_stuff_err, w_stuff_err_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  w_freeze;

  // One CRC-15 step for a single destuffed bit.
  function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
    logic n;
    n = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (n ? CRC_POLY : 15'd0);
  endfunction

  // Saturating recessive-bit counter increment.
  assign w_idle_inc = (r_idle_cnt == c_IDLE_MAX) ? r_idle_cnt : r_idle_cnt + 1'b1;

  // Register the FSM state and all datapath/output state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_IDLE;
      r_idle_cnt  <= '0;
      r_stuff_cnt <= '0;
      r_prev      <= 1'b0;
      r_crc       <= '0;
      r_crc_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_stuff_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_stuff_cnt <= w_stuff_nxt;
      r_prev      <= w_prev_nxt;
      r_crc       <= w_crc_nxt;
      r_crc_valid <= w_crc_valid_nxt;
      r_bit_out   <= w_bit_out_nxt;
      r_bit_valid <= w_bit_valid_nxt;
      r_sof       <= w_sof_nxt;
      r_stuff_err <= w_stuff_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and output decode; decoder strobes act before the coincident bit.
  always_comb begin
    w_state_nxt     = r_state;
    w_idle_nxt      = r_idle_cnt;
    w_stuff_nxt     = r_stuff_cnt;
    w_prev_nxt      = r_prev;
    w_crc_nxt       = r_crc;
    w_crc_valid_nxt = r_crc_valid;
    w_bit_out_nxt   = r_bit_out;
    w_bit_valid_nxt = 1'b0;
    w_sof_nxt       = 1'b0;
    w_stuff_err_nxt = 1'b0;
    w_busy_nxt      = r_busy;
    w_freeze        = r_crc_valid;

    case (r_state)
      S_WAIT_IDLE: begin
        if (i_sample_en) begin
          w_idle_nxt = i_rx_bit ? w_idle_inc : '0;
          if (i_rx_bit && (w_idle_inc == c_IDLE_MAX)) w_state_nxt = S_IDLE;
        end
      end

      S_IDLE: begin
        if (i_sample_en && !i_rx_bit) begin
          w_bit_out_nxt   = 1'b0;
          w_bit_valid_nxt = 1'b1;
          w_sof_nxt       = 1'b1;
          w_busy_nxt      = 1'b1;
          w_crc_valid_nxt = 1'b0;
          w_crc_nxt       = crc_step(15'd0, 1'b0);
          w_prev_nxt      = 1'b0;
          w_stuff_nxt     = c_STUFF_ONE;
          w_state_nxt     = S_STUFF;
        end
      end

      S_STUFF: begin
        if (i_frame_done) begin
          // Decoder abort: drop the frame quietly and wait for bus idle again.
          w_state_nxt = S_WAIT_IDLE;
          w_busy_nxt  = 1'b0;
          w_idle_nxt  = '0;
        end else begin
          if (i_crc_stop) begin
            w_crc_valid_nxt = 1'b1;
            w_freeze        = 1'b1;
          end
          if (i_stuff_stop) w_state_nxt = S_NOSTUFF;
          if (i_sample_en) begin
            if (i_stuff_stop) begin
              // Destuffing already over for this bit: pass it straight through.
              w_bit_out_nxt   = i_rx_bit;
              w_bit_valid_nxt = 1'b1;
            end else if (r_stuff_cnt == c_STUFF_MAX) begin
              if (i_rx_bit != r_prev) begin
                w_prev_nxt  = i_rx_bit;
                w_stuff_nxt = c_STUFF_ONE;
              end else begin
                w_stuff_err_nxt = 1'b1;
                w_idle_nxt      = '0;
                w_state_nxt     = S_ERROR;
              end
            end else begin
              w_bit_out_nxt   = i_rx_bit;
              w_bit_valid_nxt = 1'b1;
              w_stuff_nxt     = (i_rx_bit == r_prev) ? r_stuff_cnt + 1'b1 : c_STUFF_ONE;
              w_prev_nxt      = i_rx_bit;
              if (!w_freeze) w_crc_nxt = crc_step(r_crc, i_rx_bit);
            end
          end
        end
      end

      S_NOSTUFF: begin
        if (i_frame_done) begin
          w_state_nxt = S_WAIT_IDLE;
          w_busy_nxt  = 1'b0;
          w_idle_nxt  = '0;
        end else if (i_sample_en) begin
          w_bit_out_nxt   = i_rx_bit;
          w_bit_valid_nxt = 1'b1;
        end
      end

      S_ERROR: begin
        if (i_frame_done) begin
          w_state_nxt = S_WAIT_IDLE;
          w_busy_nxt  = 1'b0;
          w_idle_nxt  = '0;
        end else if (i_sample_en) begin
          // The recessive run seen here carries over, so WAIT_IDLE re-arms fast.
          w_idle_nxt = i_rx_bit ? w_idle_inc : '0;
          if (i_rx_bit && (w_idle_inc == c_IDLE_MAX)) begin
            w_state_nxt = S_WAIT_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt = S_WAIT_IDLE;
        w_busy_nxt  = 1'b0;
        w_idle_nxt  = '0;
      end
    endcase
  end

  assign o_bit_out   = r_bit_out;
  assign o_bit_valid = r_bit_valid;
  assign o_sof       = r_sof;
  assign o_crc_out   = r_crc;
  assign o_crc_valid = r_crc_valid;
  assign o_stuff_err = r_stuff_err;
  assign o_busy      = r_busy;
  assign o_seq_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_can_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_rx_sequencer
// Purpose  : Directed bench for can_rx_sequencer with a queue-based
//            scoreboard checking the destuffed bit stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_can_rx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_en = 1'b0;
  logic        r_rx = 1'b1;
  logic        r_crc_stop = 1'b0;
  logic        r_stuff_stop = 1'b0;
  logic        r_frame_done = 1'b0;
  logic        w_bit_out, w_bit_valid, w_sof, w_crc_valid, w_stuff_err, w_busy;
  logic [14:0] w_crc_out;
  logic [2:0]  w_seq_state;

  int total = 0;
  int bad = 0;
  int sof_seen = 0;
  int err_seen = 0;
  logic [1:0] exp_q[$];
  logic en_d = 1'b0;
  logic [14:0] golden;

  can_rx_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sample_en  (r_en),
    .i_rx_bit     (r_rx),
    .i_crc_stop   (r_crc_stop),
    .i_stuff_stop (r_stuff_stop),
    .i_frame_done (r_frame_done),
    .o_bit_out    (w_bit_out),
    .o_bit_valid  (w_bit_valid),
    .o_sof        (w_sof),
    .o_crc_out    (w_crc_out),
    .o_crc_valid  (w_crc_valid),
    .o_stuff_err  (w_stuff_err),
    .o_busy       (w_busy),
    .o_seq_state  (w_seq_state)
  );

  always #5 clk = ~clk;

  // Remember whether the previous cycle carried a sample strobe (latency check).
  always @(posedge clk) en_d <= r_en;

  // Reference CRC-15 over the destuffed SOF..data bits, MSB first.
  function automatic logic [14:0] crc_ref(input logic [26:0] f);
    logic [14:0] c;
    logic        n;
    c = '0;
    for (int i = 26; i >= 0; i--) begin
      n = f[i] ^ c[14];
      c = {c[13:0], 1'b0} ^ (n ? 15'h4599 : 15'h0000);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One raw bus bit: strobe for one clk, then a quiet clk.
  task automatic send(input logic b, input logic exp_v, input logic exp_sof);
    @(negedge clk);
    if (exp_v) exp_q.push_back({exp_sof, b});
    r_en = 1'b1;
    r_rx = b;
    @(negedge clk);
    r_en = 1'b0;
    r_rx = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) r_crc_stop = 1'b1;
    if (which == 1) r_stuff_stop = 1'b1;
    if (which == 2) r_frame_done = 1'b1;
    @(negedge clk);
    r_crc_stop   = 1'b0;
    r_stuff_stop = 1'b0;
    r_frame_done = 1'b0;
  endtask

  // Monitor: pop the scoreboard whenever the DUT strobes a bit.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (w_stuff_err) err_seen++;
      if (w_sof) sof_seen++;
      if (w_bit_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bitstream: unexpected strobe bit=%0d sof=%0d, required no strobe",
                   w_bit_out, w_sof);
        end else begin
          e = exp_q.pop_front();
          if (({w_sof, w_bit_out} !== e) || !en_d) begin
            bad++;
            $display("FAIL bitstream: actual sof/bit=%0d/%0d lat_ok=%0d required sof/bit=%0d/%0d lat_ok=1",
                     w_sof, w_bit_out, en_d, e[1], e[0]);
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    logic [26:0] frame;
    logic        prev;
    logic        b;
    int          cnt;

    repeat (3) @(negedge clk);
    chk("reset_state", w_seq_state, 0);
    chk("reset_busy", w_busy, 0);
    chk("reset_valid", w_bit_valid, 0);
    chk("reset_crc_valid", w_crc_valid, 0);
    chk("reset_crc_out", w_crc_out, 0);
    chk("reset_sof", w_sof, 0);
    chk("reset_err", w_stuff_err, 0);
    rst_n = 1'b1;

    // Idle detection: 10 recessive bits are not enough.
    repeat (10) send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("t1_short_idle_state", w_seq_state, 0);
    chk("t1_short_idle_sof", sof_seen, 0);
    repeat (11) send(1'b1, 1'b0, 1'b0);
    chk("t1_idle_state", w_seq_state, 1);
    send(1'b0, 1'b1, 1'b1);
    chk("t1_sof_count", sof_seen, 1);
    chk("t1_state_stuff", w_seq_state, 2);
    chk("t1_busy", w_busy, 1);

    // Stuff bit removal.
    repeat (4) send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    chk("t2_no_err", err_seen, 0);
    chk("t2_state", w_seq_state, 2);
    pulse(2);
    chk("t2_abort_state", w_seq_state, 0);
    chk("t2_abort_busy", w_busy, 0);

    // Stuff rule violation and recovery.
    repeat (11) send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    repeat (4) send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("t3_err_count", err_seen, 1);
    chk("t3_state_err", w_seq_state, 4);
    chk("t3_busy_err", w_busy, 1);
    repeat (11) send(1'b1, 1'b0, 1'b0);
    chk("t3_state_wait", w_seq_state, 0);
    chk("t3_busy_clear", w_busy, 0);
    send(1'b1, 1'b0, 1'b0);
    chk("t3_state_idle", w_seq_state, 1);

    // Standard data frame ID=0x123, DLC=1, data 0xA5, sent with stuffing.
    frame  = 27'b0_00100100011_000_0001_10100101;
    golden = crc_ref(frame);
    prev   = 1'b0;
    cnt    = 1;
    send(frame[26], 1'b1, 1'b1);
    for (int i = 25; i >= 0; i--) begin
      if (cnt == 5) begin
        send(~prev, 1'b0, 1'b0);
        prev = ~prev;
        cnt  = 1;
      end
      b = frame[i];
      send(b, 1'b1, 1'b0);
      cnt  = (b == prev) ? cnt + 1 : 1;
      prev = b;
    end
    chk("t4_crc_valid_before", w_crc_valid, 0);
    pulse(0);
    chk("t4_crc_valid", w_crc_valid, 1);
    chk("t4_crc_out", w_crc_out, golden);
    chk("t4_no_err", err_seen, 1);

    // No destuffing after stuff_stop.
    pulse(1);
    chk("t5_state_nostuff", w_seq_state, 3);
    repeat (6) send(1'b1, 1'b1, 1'b0);
    chk("t5_no_err", err_seen, 1);
    pulse(2);
    chk("t5_state_wait", w_seq_state, 0);
    chk("t5_busy", w_busy, 0);
    chk("t5_crc_hold_valid", w_crc_valid, 1);
    chk("t5_crc_hold_out", w_crc_out, golden);

    // Reset mid-frame.
    repeat (11) send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    chk("t6_crc_valid_cleared", w_crc_valid, 0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_state", w_seq_state, 0);
    chk("t6_busy", w_busy, 0);
    chk("t6_bit_out", w_bit_out, 0);
    chk("t6_crc_out", w_crc_out, 0);
    chk("t6_crc_valid", w_crc_valid, 0);
    repeat (5) send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    repeat (10) send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("t6_no_sof", sof_seen, 4);
    chk("t6_state_after", w_seq_state, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
